fxp_denorm: RTL and testbench

FXP_DENORM -- requirements
Module: fxp_denorm

---
 rtl/fxp_denorm_pkg.sv | 15 +
 rtl/fxp_denorm_shift_step.sv | 22 ++
 rtl/fxp_denorm.sv | 88 ++++++++
 tb/tb_fxp_denorm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fxp_denorm_pkg.sv
// Shared constants for the iterative fixed-point denormalizer: the Q format,
// the per-cycle shift step, the shift-count ceiling and the FSM encoding.
package fxp_denorm_pkg;
    localparam int FXP_QM        = 10;
    localparam int FXP_QN        = 10;
    localparam int DENORM_STEP   = 4;
    localparam int DENORM_MAX_SH = 20;
    localparam int SHAMT_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } denorm_state_e;
endpackage

// File: rtl/fxp_denorm_shift_step.sv
// Combinational shifter for one iteration: shifts by k in 0..STEP positions
// with zero fill and reports whether any set bit fell off the word.
module fxp_denorm_shift_step #(
    parameter int W    = 20,
    parameter int STEP = 4
) (
    input  logic [W-1:0]                 data_i,
    input  logic [$clog2(STEP+1)-1:0]    k_i,
    input  logic                         dir_i,
    output logic [W-1:0]                 data_o,
    output logic                         lost_o
);
    logic [W-1:0] lost_mask;

    always_comb begin
        // Mask selects the bits that leave the word: low bits on a right
        // shift, high bits on a left shift.
        lost_mask = dir_i ? ~({W{1'b1}} >> k_i) : ~({W{1'b1}} << k_i);
        data_o    = dir_i ? (data_i << k_i) : (data_i >> k_i);
        lost_o    = |(data_i & lost_mask);
    end
endmodule

// File: rtl/fxp_denorm.sv
// Multi-cycle fixed-point shifter: right shifts track a sticky inexact flag,
// left shifts saturate to all ones on overflow.
module fxp_denorm
    import fxp_denorm_pkg::*;
#(
    parameter int QM   = FXP_QM,
    parameter int QN   = FXP_QN,
    parameter int STEP = DENORM_STEP
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [QM+QN-1:0]    i_data,
    input  logic [SHAMT_W-1:0]  i_shamt,
    input  logic                i_dir,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [QM+QN-1:0]    o_data,
    output logic                o_sat,
    output logic                o_inexact
);
    localparam int W  = QM + QN;
    localparam int KW = $clog2(STEP + 1);

    denorm_state_e      state_q;
    logic [W-1:0]       data_q;
    logic [SHAMT_W-1:0] rem_q;
    logic               dir_q;
    logic               sat_q;
    logic               inx_q;

    logic [SHAMT_W-1:0] shamt_clamped;
    logic [KW-1:0]      k;
    logic [W-1:0]       data_d;
    logic               lost;

    assign shamt_clamped = (i_shamt > SHAMT_W'(DENORM_MAX_SH)) ? SHAMT_W'(DENORM_MAX_SH)
                                                                : i_shamt;
    assign k = (rem_q > SHAMT_W'(STEP)) ? KW'(STEP) : KW'(rem_q);

    fxp_denorm_shift_step #(.W(W), .STEP(STEP)) u_step (
        .data_i (data_q),
        .k_i    (k),
        .dir_i  (dir_q),
        .data_o (data_d),
        .lost_o (lost)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            sat_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (i_valid) begin
                    data_q  <= i_data;
                    dir_q   <= i_dir;
                    rem_q   <= shamt_clamped;
                    sat_q   <= 1'b0;
                    inx_q   <= 1'b0;
                    state_q <= (shamt_clamped != '0) ? ST_SHIFT : ST_DONE;
                end
                ST_SHIFT: begin
                    data_q <= data_d;
                    rem_q  <= rem_q - SHAMT_W'(k);
                    sat_q  <= sat_q | (dir_q & lost);
                    inx_q  <= inx_q | (~dir_q & lost);
                    if (rem_q == SHAMT_W'(k))
                        state_q <= ST_DONE;
                end
                ST_DONE: if (i_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready   = (state_q == ST_IDLE);
    assign o_valid   = (state_q == ST_DONE);
    // Saturation overrides whatever partial word the shifts left behind.
    assign o_data    = (o_valid && sat_q) ? {W{1'b1}} : data_q;
    assign o_sat     = sat_q;
    assign o_inexact = inx_q;
endmodule

// File: tb/tb_fxp_denorm.sv
// Self-checking bench for fxp_denorm: directed corner cases plus a random
// sweep against an arithmetic reference model.
module tb_fxp_denorm;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [19:0] i_data = '0;
    logic [4:0]  i_shamt = '0;
    logic        i_dir = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [19:0] o_data;
    logic        o_sat;
    logic        o_inexact;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fxp_denorm dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_shamt   (i_shamt),
        .i_dir     (i_dir),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_sat     (o_sat),
        .o_inexact (o_inexact)
    );

    // Reference: plain arithmetic on the clamped count.
    task automatic ref_model(input logic [19:0] d, input logic [4:0] sh, input logic dir,
                             output logic [19:0] res, output logic sat, output logic inx,
                             output int lat);
        longint n, full, p;
        n   = (sh > 20) ? 20 : sh;
        p   = longint'(1) << n;
        lat = int'((n + 3) / 4);
        sat = 1'b0;
        inx = 1'b0;
        if (!dir) begin
            res = 20'(longint'(d) / p);
            inx = (longint'(d) % p) != 0;
        end else begin
            full = longint'(d) * p;
            sat  = full > 64'hFFFFF;
            res  = sat ? 20'hFFFFF : 20'(full);
        end
    endtask

    // Drive one request, wait (bounded) for o_valid; i_ready is left low.
    task automatic run_req(input logic [19:0] d, input logic [4:0] sh, input logic dir,
                           output int lat, output logic [19:0] od, output logic os,
                           output logic oi, output bit timeout);
        @(negedge clk);
        i_valid = 1'b1; i_data = d; i_shamt = sh; i_dir = dir; i_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs so a design that re-samples them would be caught.
        i_valid = 1'b0; i_data = 20'($urandom); i_shamt = 5'($urandom); i_dir = 1'($urandom);
        lat = 0;
        while (!o_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        timeout = !o_valid;
        od = o_data; os = o_sat; oi = o_inexact;
    endtask

    task automatic finish_req();
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 20'h0 ||
            o_sat !== 1'b0 || o_inexact !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h sat=%b inx=%b required rdy=1 vld=0 data=0 flags=0",
                     o_ready, o_valid, o_data, o_sat, o_inexact);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [19:0] dv [6] = '{20'h80000, 20'h00400, 20'h00401, 20'h00003, 20'h80000, 20'h00000};
        logic [4:0]  sv [6] = '{5'd9, 5'd9, 5'd10, 5'd1, 5'd25, 5'd31};
        logic        rv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [19:0] ed [6] = '{20'h00400, 20'h80000, 20'hFFFFF, 20'h00001, 20'h00000, 20'h00000};
        logic        es [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ei [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int          el [6] = '{3, 3, 3, 1, 5, 5};
        int lat; logic [19:0] od; logic os, oi; bit to;
        for (int i = 0; i < 6; i++) begin
            run_req(dv[i], sv[i], rv[i], lat, od, os, oi, to);
            checks++;
            if (to || od !== ed[i] || os !== es[i] || oi !== ei[i] || lat != el[i]) begin
                errors++;
                $display("FAIL directed_%0d: timeout=%0b data=%h sat=%b inx=%b lat=%0d required data=%h sat=%b inx=%b lat=%0d",
                         i, to, od, os, oi, lat, ed[i], es[i], ei[i], el[i]);
            end
            finish_req();
        end
    endtask

    task automatic test_hold();
        int lat; logic [19:0] od; logic os, oi; bit to;
        run_req(20'h12345, 5'd0, 1'b0, lat, od, os, oi, to);
        checks++;
        if (to || lat != 0 || od !== 20'h12345 || os !== 1'b0 || oi !== 1'b0) begin
            errors++;
            $display("FAIL zero_shift: timeout=%0b lat=%0d data=%h sat=%b inx=%b required lat=0 data=12345 flags=0",
                     to, lat, od, os, oi);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            i_valid = 1'b1; i_data = 20'hABCDE; i_shamt = 5'd3; i_dir = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== 20'h12345 ||
                o_sat !== 1'b0 || o_inexact !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall_%0d: vld=%b rdy=%b data=%h sat=%b inx=%b required vld=1 rdy=0 data=12345 flags=0",
                         c, o_valid, o_ready, o_data, o_sat, o_inexact);
            end
        end
        finish_req();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: vld=%b rdy=%b required vld=0 rdy=1", o_valid, o_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [19:0] od; logic os, oi; bit to;
        @(negedge clk);
        i_valid = 1'b1; i_data = 20'hFFFFF; i_shamt = 5'd20; i_dir = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 20'h0 ||
            o_sat !== 1'b0 || o_inexact !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b vld=%b data=%h sat=%b inx=%b required rdy=1 vld=0 data=0 flags=0",
                     o_ready, o_valid, o_data, o_sat, o_inexact);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_req(20'h00C00, 5'd4, 1'b0, lat, od, os, oi, to);
        checks++;
        if (to || od !== 20'h000C0 || os !== 1'b0 || oi !== 1'b0 || lat != 1) begin
            errors++;
            $display("FAIL after_reset: timeout=%0b data=%h sat=%b inx=%b lat=%0d required data=000c0 flags=0 lat=1",
                     to, od, os, oi, lat);
        end
        finish_req();
    endtask

    task automatic test_back_to_back();
        int lat, elat; logic [19:0] od, ed; logic os, oi, es, ei; bit to;
        logic [19:0] d; logic [4:0] sh; logic dir;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       d = '0;
                1:       d = 20'h1 << $urandom_range(0, 19);
                default: d = 20'($urandom);
            endcase
            sh  = 5'($urandom_range(0, 31));
            dir = 1'($urandom);
            ref_model(d, sh, dir, ed, es, ei, elat);
            run_req(d, sh, dir, lat, od, os, oi, to);
            checks++;
            if (to || od !== ed || os !== es || oi !== ei || lat != elat) begin
                errors++;
                $display("FAIL random_%0d d=%h sh=%0d dir=%0b: timeout=%0b data=%h sat=%b inx=%b lat=%0d required data=%h sat=%b inx=%b lat=%0d",
                         i, d, sh, dir, to, od, os, oi, lat, ed, es, ei, elat);
            end
            finish_req();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
